// File: rtl/popcount_engine.sv
// Multi-cycle population counter: sums CHUNK bits per clock, LSB-first, and
// reports ones/zeros count or a one-hot / one-hot-or-zero flag.
module popcount_engine #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [1:0]                 in_mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(WIDTH+1)-1:0] out_count,
   output logic                       out_flag
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = $clog2(WIDTH + 1);
   localparam int CCW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   shift_q, shift_d;
   logic [1:0]         mode_q, mode_d;
   logic [CNT_W-1:0]   acc_q, acc_d;
   logic [CCW-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]   out_count_q, out_count_d;
   logic               out_flag_q, out_flag_d;

   logic [CNT_W-1:0]   chunk_pop;
   logic [CNT_W-1:0]   ones;
   logic [CNT_W-1:0]   res_count;

   always_comb begin
      chunk_pop = '0;
      for (int i = 0; i < CHUNK; i++)
         chunk_pop = chunk_pop + CNT_W'(shift_q[i]);
   end

   // Final tally is formed from the last chunk directly so the result can be
   // registered on the same edge that enters DONE.
   assign ones      = acc_q + chunk_pop;
   assign res_count = (mode_q == 2'd1) ? CNT_W'(WIDTH) - ones : ones;

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_count_d = out_count_q;
      out_flag_d  = out_flag_q;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               shift_d = in_data;
               mode_d  = in_mode;
               acc_d   = '0;
               cnt_d   = CCW'(NCHUNK - 1);
               state_d = COUNT;
            end
         end
         COUNT: begin
            acc_d   = ones;
            shift_d = WIDTH'(shift_q >> CHUNK);
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               cnt_d       = '0;
               out_count_d = res_count;
               case (mode_q)
                  2'd2:    out_flag_d = (ones == CNT_W'(1));
                  2'd3:    out_flag_d = (ones <= CNT_W'(1));
                  default: out_flag_d = res_count[0];
               endcase
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         mode_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_count_q <= '0;
         out_flag_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_count_q <= out_count_d;
         out_flag_q  <= out_flag_d;
      end
   end

   assign out_count = out_count_q;
   assign out_flag  = out_flag_q;

endmodule
